spi_master_ms: RTL
==================

SPI_MASTER_MS -- requirements
Module: spi_master_ms

Interface
REQ-001 Parameter DW, 8, transfer width in bits (2..32).
REQ-002 Parameter NSS, 4, number of active-low slave-select outputs (1..16); SW = max(1, clog2(NSS)).
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 din  in  DW  transmit word, sampled on an accepted start.
REQ-006 dvsr  in  16  half SCLK period minus one, in clk cycles (half period = dvsr+1).
REQ-007 start  in  1  transfer request; accepted only while ready=1.
REQ-008 cpol, cpha  in  1 each  SPI mode bits.
REQ-009 lsb_first  in  1  1 = bit order LSB first, 0 = MSB first.
REQ-010 ss_sel  in  SW  slave index; ss_hold  in  1  keep SS asserted after the transfer.
REQ-011 dout  out  DW  received word; spi_done_tick  out  1  one-cycle completion pulse; ready  out  1  idle indicator.
REQ-012 sclk, mosi  out  1 each; miso  in  1; ss_n  out  NSS  registered slave selects.

Function
REQ-013 States: IDLE, SETUP, P0, P1; ready=1 only in IDLE (combinational).
REQ-014 Start accepted in IDLE: latch din, ss_sel, cpol, cpha, lsb_first, ss_hold; clear bit counter and divider.
REQ-015 After acceptance, ss_n[ss_sel] goes low on the next edge and all other bits stay high.
REQ-016 SETUP lasts dvsr+1 cycles, then enters P0; SETUP is skipped (IDLE->P0) when SS is still held from the previous transfer to the same ss_sel.
REQ-017 Held SS with a different ss_sel: old bit released and new bit asserted on the same edge, then SETUP is entered.
REQ-018 P0 and P1 each last dvsr+1 cycles; miso is shifted in on the P0->P1 transition; mosi shifts on the P1->P0 transition.
REQ-019 mosi = current transmit bit: din[DW-1-k] for MSB-first, din[k] for LSB-first, k = bit index; valid from SETUP entry (or P0 entry when SETUP is skipped).
REQ-020 sclk registered: cpol XOR (cpha ? next_state==P0 : next_state==P1); in IDLE and SETUP sclk = latched cpol (live cpol input while IDLE).
REQ-021 Exactly DW P0/P1 pairs; on the end of the last P1: spi_done_tick=1 for one cycle, dout updated, state -> IDLE.
REQ-022 dout holds the first received bit at dout[DW-1] (MSB-first) or dout[0] (LSB-first); stable until the next completion.
REQ-023 On completion with ss_hold=0 all ss_n go high on the same edge IDLE is entered; with ss_hold=1 ss_n is unchanged.
REQ-024 start while busy is ignored; din, dvsr, cpol, cpha, lsb_first, ss_sel changes mid-transfer have no effect except dvsr (read live per half period).
REQ-025 ss_sel >= NSS: transfer runs with no ss_n asserted.
REQ-026 Duration of a non-held transfer from the start edge to spi_done_tick = (2*DW+1)*(dvsr+1)+1 cycles.

Reset
REQ-027 reset asserted at any time forces IDLE immediately: ss_n all ones, sclk=0, mosi=0, dout=0, spi_done_tick=0, counters and held-SS flag cleared; an in-flight transfer is abandoned without a done tick.

Configuration
REQ-028 Macro SPI_LOOPBACK_EN defined: adds input port loopback (1 bit); when loopback=1 the sampled bit is internal mosi instead of miso, and sclk, mosi and ss_n behave unchanged.
REQ-029 Macro SPI_LOOPBACK_EN undefined: no loopback port; miso is always sampled.

Verification
REQ-030 DW=8, mode 0, dvsr=1, MSB-first, din=0xA5, miso from slave model sending 0x3C -> mosi bits 1,0,1,0,0,1,0,1; dout=0x3C; done 35 cycles after start.
REQ-031 Modes 1, 2 and 3 with din=0x81, dvsr=3 -> sclk idle level = cpol, 16 edges, sampling on the correct edge, dout matches the model in every mode.
REQ-032 lsb_first=1, din=0x01, slave sends 0x80 LSB-first -> mosi first bit 1; dout=0x80.
REQ-033 Two starts, ss_sel=2, first with ss_hold=1 -> ss_n=4'b1011 continuous between transfers; second transfer has no SETUP; ss_n=4'hF after the second done.
REQ-034 reset pulsed at bit 4 -> next cycle ss_n=4'hF, ready=1, no done tick; a new transfer then completes correctly.
REQ-035 With SPI_LOOPBACK_EN, loopback=1, din=0x5A, miso tied 0 -> dout=0x5A.

Source files
------------

// File: rtl/spi_master_ms_if.sv
// spi_master_ms_if: SPI bus lines shared by the master and its slaves
interface spi_master_ms_if #(parameter int NSS = 4);
   logic sclk, mosi, miso;
   logic [NSS-1:0] ss_n;
   modport master (output sclk, mosi, ss_n, input miso);
   modport slave (input sclk, mosi, ss_n, output miso);
endinterface

// File: rtl/spi_master_ms.sv
// spi_master_ms: SPI master (modes 0-3, MSB/LSB first, multi-slave select with hold); define SPI_LOOPBACK_EN to add a loopback input
module spi_master_ms #(
   parameter int DW = 8,
   parameter int NSS = 4,
   localparam int SW = NSS > 1 ? $clog2(NSS) : 1
) (
   input  logic clk,
   input  logic reset,
   input  logic [DW-1:0] din,
   input  logic [15:0] dvsr,
   input  logic start,
   input  logic cpol,
   input  logic cpha,
   input  logic lsb_first,
   input  logic [SW-1:0] ss_sel,
   input  logic ss_hold,
`ifdef SPI_LOOPBACK_EN
   input  logic loopback,
`endif
   output logic [DW-1:0] dout,
   output logic spi_done_tick,
   output logic ready,
   spi_master_ms_if.master spi
);
   localparam int IW = $clog2(DW);
   typedef enum logic [1:0] {IDLE, SETUP, P0, P1} state_t;
   state_t state, state_nx;
   logic [15:0] cnt;
   logic [IW-1:0] idx;
   logic [DW-1:0] tx, rx;
   logic [SW-1:0] sel;
   logic cpol_r, cpha_r, lsb_r, hold_r, held;
   logic tick, skip, last, cp, ch, in_bit;
   assign ready = state == IDLE;
   assign tick = cnt >= dvsr;
   assign skip = held && sel == ss_sel;
   assign last = idx == IW'(DW - 1);
   assign cp = ready ? cpol : cpol_r;
   assign ch = ready ? cpha : cpha_r;
`ifdef SPI_LOOPBACK_EN
   assign in_bit = loopback ? spi.mosi : spi.miso;
`else
   assign in_bit = spi.miso;
`endif
   assign state_nx = ready ? (start ? (skip ? P0 : SETUP) : IDLE)
                   : !tick ? state
                   : state == SETUP ? P0
                   : state == P0 ? P1
                   : last ? IDLE : P0;
   // tx is stored in transmit order so the bit index addresses it directly
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         idx <= '0;
         tx <= '0;
         rx <= '0;
         sel <= '0;
         cpol_r <= 1'b0;
         cpha_r <= 1'b0;
         lsb_r <= 1'b0;
         hold_r <= 1'b0;
         held <= 1'b0;
         dout <= '0;
         spi_done_tick <= 1'b0;
         spi.sclk <= 1'b0;
         spi.mosi <= 1'b0;
         spi.ss_n <= '1;
      end else begin
         state <= state_nx;
         spi_done_tick <= 1'b0;
         spi.sclk <= (state_nx == IDLE || state_nx == SETUP) ? cp : cp ^ (ch ? state_nx == P0 : state_nx == P1);
         cnt <= (ready || tick) ? '0 : cnt + 16'd1;
         if (ready) begin
            if (start) begin
               tx <= lsb_first ? din : {<<{din}};
               sel <= ss_sel;
               cpol_r <= cpol;
               cpha_r <= cpha;
               lsb_r <= lsb_first;
               hold_r <= ss_hold;
               idx <= '0;
               spi.mosi <= lsb_first ? din[0] : din[DW-1];
               if (!skip) spi.ss_n <= ~(NSS'(1) << ss_sel);
            end
         end else if (tick) begin
            if (state == P0) rx <= lsb_r ? {in_bit, rx[DW-1:1]} : {rx[DW-2:0], in_bit};
            if (state == P1) begin
               if (last) begin
                  dout <= rx;
                  spi_done_tick <= 1'b1;
                  held <= hold_r;
                  if (!hold_r) spi.ss_n <= '1;
               end else begin
                  idx <= idx + 1'b1;
                  spi.mosi <= tx[idx + IW'(1)];
               end
            end
         end
      end
endmodule
